// File: rtl/alu_pkg.sv
// Shared definitions for the UART calculator arithmetic unit.
// Opcode encoding, divider state encoding and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_e;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    // True when a 2W-bit signed value's top W+1 bits are all equal,
    // i.e. it is representable in W signed bits.
    function automatic logic upper_is_sign_ext(input logic [ALU_WIDTH:0] upper);
        return (&upper) || !(|upper);
    endfunction

endpackage

// File: rtl/alu_div.sv
// Sequential signed divider: sign/magnitude split, unsigned restoring
// loop producing one quotient bit per clock, sign fix-up at the end.
module alu_div
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic signed [WIDTH-1:0] i_dividend,
    input  logic signed [WIDTH-1:0] i_divisor,
    output logic signed [WIDTH-1:0] o_quotient,
    output logic                    o_ovf,
    output logic                    o_done,
    output logic                    o_busy
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_last;

    assign w_a_neg = i_dividend[WIDTH-1];
    assign w_b_neg = i_divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~i_dividend + WIDTH'(1)) : i_dividend;
    assign w_b_mag = w_b_neg ? (~i_divisor + WIDTH'(1)) : i_divisor;

    // Partial remainder with the next dividend bit shifted in.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};
    assign w_last  = (r_cnt == CW'(WIDTH));

    // Load magnitudes on start, then one restoring step per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg   <= 1'b0;
        end else begin
            unique case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_state <= DIV_RUN;
                        r_cnt   <= '0;
                        r_q     <= w_a_mag;
                        r_rem   <= '0;
                        r_dvs   <= w_b_mag;
                        r_neg   <= w_a_neg ^ w_b_neg;
                    end
                end
                DIV_RUN: begin
                    if (w_last) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state == DIV_RUN);
    assign o_done     = o_busy && w_last;
    assign o_quotient = r_neg ? (~r_q + WIDTH'(1)) : r_q;
    // A same-sign magnitude with the top bit set only arises from MIN / -1.
    assign o_ovf      = !r_neg && r_q[WIDTH-1];

endmodule

// File: rtl/alu.sv
// Signed arithmetic unit for the UART calculator: single-cycle add,
// sub and mul, multi-cycle divide, registered result/error/done.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              opcode,
    input  logic signed [WIDTH-1:0] op1,
    input  logic signed [WIDTH-1:0] op2,
    output logic signed [WIDTH-1:0] result,
    output logic                    error,
    output logic                    done,
    output logic                    busy
);

    logic signed [WIDTH-1:0] r_result;
    logic                    r_error;
    logic                    r_done;

    opcode_e                 w_op;
    logic                    w_accept;
    logic                    w_div_zero;
    logic                    w_div_start;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH:0]          w_diff;
    logic [2*WIDTH-1:0]      w_prod;
    logic                    w_prod_ovf;
    logic [WIDTH-1:0]        w_fast_res;
    logic                    w_fast_err;
    logic signed [WIDTH-1:0] w_div_q;
    logic                    w_div_ovf;
    logic                    w_div_done;
    logic                    w_div_busy;

    assign w_op        = opcode_e'(opcode);
    assign w_accept    = start && !w_div_busy;
    assign w_div_zero  = (op2 == '0);
    assign w_div_start = w_accept && (w_op == OP_DIV) && !w_div_zero;

    assign w_sum  = {op1[WIDTH-1], op1} + {op2[WIDTH-1], op2};
    assign w_diff = {op1[WIDTH-1], op1} - {op2[WIDTH-1], op2};
    assign w_prod = {{WIDTH{op1[WIDTH-1]}}, op1}
                  * {{WIDTH{op2[WIDTH-1]}}, op2};

    generate
        if (WIDTH == ALU_WIDTH) begin : g_ovf_pkg
            assign w_prod_ovf = !upper_is_sign_ext(w_prod[2*WIDTH-1:WIDTH-1]);
        end else begin : g_ovf_gen
            assign w_prod_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1])
                               || !(|w_prod[2*WIDTH-1:WIDTH-1]));
        end
    endgenerate

    // Single-cycle result select; the div entry is the divide-by-zero path.
    always_comb begin
        w_fast_res = '0;
        w_fast_err = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                w_fast_res = w_sum[WIDTH-1:0];
                w_fast_err = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            OP_SUB: begin
                w_fast_res = w_diff[WIDTH-1:0];
                w_fast_err = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            end
            OP_MUL: begin
                w_fast_res = w_prod[WIDTH-1:0];
                w_fast_err = w_prod_ovf;
            end
            OP_DIV: begin
                w_fast_res = '0;
                w_fast_err = 1'b1;
            end
        endcase
    end

    alu_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (op1),
        .i_divisor  (op2),
        .o_quotient (w_div_q),
        .o_ovf      (w_div_ovf),
        .o_done     (w_div_done),
        .o_busy     (w_div_busy)
    );

    // Output registers: load on a fast completion or on divider finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_error  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_div_start) begin
                r_result <= w_fast_res;
                r_error  <= w_fast_err;
                r_done   <= 1'b1;
            end else if (w_div_done) begin
                r_result <= w_div_q;
                r_error  <= w_div_ovf;
                r_done   <= 1'b1;
            end
        end
    end

    assign result = r_result;
    assign error  = r_error;
    assign done   = r_done;
    assign busy   = w_div_busy;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand sequences
// for back-to-back, ignored start and reset abort, then random ops.
module tb_alu;

    logic               clk;
    logic               rst;
    logic               start;
    logic [1:0]         opcode;
    logic signed [15:0] op1;
    logic signed [15:0] op2;
    logic signed [15:0] result;
    logic               error;
    logic               done;
    logic               busy;

    int n_vec;
    int n_err;

    typedef struct {
        logic [1:0] op;
        int         a;
        int         b;
        int         res;
        bit         err;
        string      name;
    } vec_t;

    vec_t tbl[14];

    alu #(
        .WIDTH (16)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .op1    (op1),
        .op2    (op2),
        .result (result),
        .error  (error),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range test and truncation.
    function automatic void model(input logic [1:0] op, input int a, input int b,
                                  output int r, output bit e);
        longint x;
        case (op)
            2'd0: x = longint'(a) + b;
            2'd1: x = longint'(a) - b;
            2'd2: x = longint'(a) * b;
            default: begin
                if (b == 0) begin
                    r = 0;
                    e = 1'b1;
                    return;
                end
                x = longint'(a) / b;
            end
        endcase
        e = (x > 32767) || (x < -32768);
        r = int'($signed(x[15:0]));
    endfunction

    task automatic run_op(input logic [1:0] op, input int a, input int b,
                          input int exp_res, input bit exp_err, input string tag);
        int n;
        int nbusy;
        int exp_edges;
        exp_edges = (op == 2'd3 && b != 0) ? 17 : 0;
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        op1    = 16'(a);
        op2    = 16'(b);
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        nbusy = 0;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, longint'(done), 1);
        check({tag, " latency"}, n, exp_edges);
        check({tag, " result"}, result, exp_res);
        check({tag, " error"}, longint'(error), longint'(exp_err));
        check({tag, " busy cycles"}, nbusy, exp_edges);
        check({tag, " busy at done"}, longint'(busy), 0);
        @(negedge clk);
        check({tag, " done width"}, longint'(done), 0);
    endtask

    initial begin
        int r;
        bit e;
        int n;
        int ndone;
        logic [1:0] op;
        int a;
        int b;
        int picks[5];

        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        opcode = 2'd0;
        op1    = 16'sd0;
        op2    = 16'sd0;

        tbl[0]  = '{2'd0, 15, 5, 20, 1'b0, "15+5"};
        tbl[1]  = '{2'd1, 15, 5, 10, 1'b0, "15-5"};
        tbl[2]  = '{2'd2, 15, 5, 75, 1'b0, "15*5"};
        tbl[3]  = '{2'd3, 15, 5, 3, 1'b0, "15/5"};
        tbl[4]  = '{2'd3, -7, 2, -3, 1'b0, "-7/2"};
        tbl[5]  = '{2'd3, 7, -2, -3, 1'b0, "7/-2"};
        tbl[6]  = '{2'd3, -32768, -1, -32768, 1'b1, "min/-1"};
        tbl[7]  = '{2'd3, 15, 0, 0, 1'b1, "15/0"};
        tbl[8]  = '{2'd0, 32767, 1, -32768, 1'b1, "max+1"};
        tbl[9]  = '{2'd1, -32768, 1, 32767, 1'b1, "min-1"};
        tbl[10] = '{2'd2, 300, 300, 24464, 1'b1, "300*300"};
        tbl[11] = '{2'd2, -128, 256, -32768, 1'b0, "-128*256"};
        tbl[12] = '{2'd3, -32768, 1, -32768, 1'b0, "min/1"};
        tbl[13] = '{2'd3, 32767, -32768, 0, 1'b0, "max/min"};

        repeat (3) @(negedge clk);
        check("reset result", result, 0);
        check("reset error", longint'(error), 0);
        check("reset done", longint'(done), 0);
        check("reset busy", longint'(busy), 0);
        rst = 1'b0;

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].err, tbl[i].name);

        // Back-to-back single-cycle ops: one done per cycle.
        @(negedge clk);
        start = 1'b1; opcode = 2'd0; op1 = 16'sd15; op2 = 16'sd5;
        @(negedge clk);
        check("b2b add done", longint'(done), 1);
        check("b2b add result", result, 20);
        opcode = 2'd1;
        @(negedge clk);
        check("b2b sub done", longint'(done), 1);
        check("b2b sub result", result, 10);
        opcode = 2'd2;
        @(negedge clk);
        check("b2b mul done", longint'(done), 1);
        check("b2b mul result", result, 75);
        check("b2b mul error", longint'(error), 0);
        start = 1'b0;
        @(negedge clk);
        check("b2b idle done", longint'(done), 0);

        // Start during a division is ignored.
        start = 1'b1; opcode = 2'd3; op1 = 16'sd15; op2 = 16'sd5;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (n == 5) begin
                start = 1'b1; opcode = 2'd0; op1 = 16'sd1; op2 = 16'sd1;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check("ignore latency", n, 17);
        check("ignore result", result, 3);
        check("ignore error", longint'(error), 0);
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignore extra done", ndone, 0);

        // Reset during a division aborts it without a done.
        start = 1'b1; opcode = 2'd3; op1 = 16'sd100; op2 = 16'sd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before", longint'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort result", result, 0);
        check("abort error", longint'(error), 0);
        check("abort busy", longint'(busy), 0);
        check("abort done", longint'(done), 0);
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort late done", ndone, 0);
        run_op(2'd0, 2, 3, 5, 1'b0, "post-abort add");

        // Random operations against the arithmetic model.
        picks = '{-32768, -1, 0, 1, 32767};
        for (int k = 0; k < 150; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)]
                                             : int'($urandom_range(0, 65535)) - 32768;
            b  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)]
                                             : int'($urandom_range(0, 65535)) - 32768;
            model(op, a, b, r, e);
            run_op(op, a, b, r, e, $sformatf("rand%0d op%0d %0d,%0d", k, op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
